// File: rtl/pingpong_buffer_nch_pkg.sv
// Shared constants and types for the N-channel ping-pong frame buffer.
package pingpong_buffer_nch_pkg;

  localparam int unsigned MEM_DEPTH_FFT  = 1200;
  localparam int unsigned MEM_DEPTH_IFFT = 2048;
  localparam int unsigned WIDTH_FFT      = 18;
  localparam int unsigned WIDTH_IFFT     = 26;
  localparam int unsigned N_BANKS        = 2;

  typedef logic bank_t;

  function automatic bank_t other_bank(bank_t b);
    return ~b;
  endfunction

endpackage

// File: rtl/pingpong_buffer_nch_if.sv
// Producer/consumer bus of the ping-pong frame buffer; master drives strobes, slave is the buffer.
interface pingpong_buffer_nch_if
  import pingpong_buffer_nch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WIDTH_FFT,
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_FFT,
  parameter int unsigned N_CH       = 2
);
  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned WORD_W = N_CH * DATA_WIDTH;

  logic              flush;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_avail;
  logic [LEN_W-1:0]  frame_len;
  logic              rd_release;
  logic              overrun;

  modport master (
    output flush, wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_release,
    input  wr_ready, rd_data, rd_valid, frame_avail, frame_len, overrun
  );

  modport slave (
    input  flush, wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_release,
    output wr_ready, rd_data, rd_valid, frame_avail, frame_len, overrun
  );

endinterface

// File: rtl/ppbuf_bank_ram.sv
// Simple dual-port synchronous RAM holding one bank: one write port, one registered read port.
module ppbuf_bank_ram #(
  parameter  int unsigned WIDTH = 36,
  parameter  int unsigned DEPTH = 1200,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pingpong_buffer_nch.sv
// N-channel ping-pong frame buffer: two banks, variable frame length, zero-pad reads, release handshake.
// Define PPBUF_OUT_REG_EN to add an output register stage on rd_data/rd_valid (read latency 2).
module pingpong_buffer_nch
  import pingpong_buffer_nch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WIDTH_FFT,
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_FFT,
  parameter int unsigned N_CH       = 2
) (
  input logic                  clk,
  input logic                  reset,
  pingpong_buffer_nch_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned WORD_W = N_CH * DATA_WIDTH;

  logic [N_BANKS-1:0]            full_q, full_nxt;
  logic [N_BANKS-1:0][LEN_W-1:0] len_q, len_nxt;
  bank_t                         wr_bank_q, wr_bank_nxt;
  bank_t                         rd_bank_q, rd_bank_nxt;
  logic                          wr_ready_q, wr_ready_nxt;
  logic                          frame_avail_q, frame_avail_nxt;
  logic [LEN_W-1:0]              frame_len_q, frame_len_nxt;
  logic                          overrun_q, overrun_nxt;

  logic wr_in_range, rd_in_range, rd_pad;
  logic wr_acc, rel_acc, rd_acc;

  logic                           rd_valid_q, rd_pad_q;
  bank_t                          rd_sel_q;
  logic [N_BANKS-1:0][WORD_W-1:0] ram_rdata;
  logic [WORD_W-1:0]              rd_data_s1;

  // Next-state for flags, lengths and bank pointers; all decisions use start-of-cycle state
  always_comb begin
    full_nxt    = full_q;
    len_nxt     = len_q;
    wr_bank_nxt = wr_bank_q;
    rd_bank_nxt = rd_bank_q;

    wr_in_range = {1'b0, bus.wr_addr} < LEN_W'(MEM_DEPTH);
    rd_in_range = {1'b0, bus.rd_addr} < LEN_W'(MEM_DEPTH);
    rd_pad      = !({1'b0, bus.rd_addr} < len_q[rd_bank_q]);

    wr_acc  = bus.wr_en && !bus.flush && !full_q[wr_bank_q] && wr_in_range;
    rel_acc = bus.rd_release && !bus.flush && full_q[rd_bank_q];
    rd_acc  = bus.rd_en && !bus.flush && full_q[rd_bank_q];
    overrun_nxt = bus.wr_en && !bus.flush && !wr_acc;

    if (bus.flush) begin
      full_nxt    = '0;
      wr_bank_nxt = 1'b0;
      rd_bank_nxt = 1'b0;
    end else begin
      if (wr_acc && bus.wr_last) begin
        len_nxt[wr_bank_q]  = LEN_W'(bus.wr_addr) + LEN_W'(1);
        full_nxt[wr_bank_q] = 1'b1;
        wr_bank_nxt         = other_bank(wr_bank_q);
      end
      // Commit and release can never target the same bank in one cycle
      if (rel_acc) begin
        full_nxt[rd_bank_q] = 1'b0;
        rd_bank_nxt         = other_bank(rd_bank_q);
      end
    end

    wr_ready_nxt    = !full_nxt[wr_bank_nxt];
    frame_avail_nxt = full_nxt[rd_bank_nxt];
    frame_len_nxt   = full_nxt[rd_bank_nxt] ? len_nxt[rd_bank_nxt] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q        <= '0;
      len_q         <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_ready_q    <= 1'b1;
      frame_avail_q <= 1'b0;
      frame_len_q   <= '0;
      overrun_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_sel_q      <= 1'b0;
      rd_pad_q      <= 1'b1;
    end else begin
      full_q        <= full_nxt;
      len_q         <= len_nxt;
      wr_bank_q     <= wr_bank_nxt;
      rd_bank_q     <= rd_bank_nxt;
      wr_ready_q    <= wr_ready_nxt;
      frame_avail_q <= frame_avail_nxt;
      frame_len_q   <= frame_len_nxt;
      overrun_q     <= overrun_nxt;
      rd_valid_q    <= rd_acc;
      // Bank select and pad flag only move on an accepted read so rd_data holds otherwise
      if (rd_acc) begin
        rd_sel_q <= rd_bank_q;
        rd_pad_q <= rd_pad;
      end
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    ppbuf_bank_ram #(
      .WIDTH (WORD_W),
      .DEPTH (MEM_DEPTH)
    ) u_ram (
      .clk   (clk),
      .we    (wr_acc && (wr_bank_q == 1'(b))),
      .waddr (bus.wr_addr),
      .wdata (bus.wr_data),
      .re    (rd_acc && rd_in_range && (rd_bank_q == 1'(b))),
      .raddr (bus.rd_addr),
      .rdata (ram_rdata[b])
    );
  end

  assign rd_data_s1 = rd_pad_q ? '0 : ram_rdata[rd_sel_q];

`ifdef PPBUF_OUT_REG_EN
  logic              rd_valid_q2;
  logic [WORD_W-1:0] rd_data_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q2 <= 1'b0;
      rd_data_q2  <= '0;
    end else begin
      rd_valid_q2 <= rd_valid_q;
      rd_data_q2  <= rd_data_s1;
    end
  end

  assign bus.rd_valid = rd_valid_q2;
  assign bus.rd_data  = rd_data_q2;
`else
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_s1;
`endif

  assign bus.wr_ready    = wr_ready_q;
  assign bus.frame_avail = frame_avail_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_pingpong_buffer_nch.sv
// Directed bench for pingpong_buffer_nch (DATA_WIDTH 18, MEM_DEPTH 1200, N_CH 2).
module tb_pingpong_buffer_nch;
  localparam int unsigned DW     = 18;
  localparam int unsigned DEPTH  = 1200;
  localparam int unsigned NCH    = 2;
  localparam int unsigned ADDR_W = 11;

  logic clk = 1'b0;
  logic reset;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  pingpong_buffer_nch_if #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .N_CH(NCH)) bus ();

  pingpong_buffer_nch #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .N_CH(NCH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [35:0] pat(input int f, input int i);
    return {18'(f * 1000 + i), 18'(262143 - f * 50 - i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [35:0] d, input logic last);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(a);
    bus.wr_data = d;
    bus.wr_last = last;
    tick();
    bus.wr_en   = 1'b0;
    bus.wr_last = 1'b0;
  endtask

  task automatic rd(input int a, input logic [35:0] exp, input string tag);
    bus.rd_en   = 1'b1;
    bus.rd_addr = ADDR_W'(a);
    tick();
    bus.rd_en   = 1'b0;
`ifdef PPBUF_OUT_REG_EN
    check({tag, "_lat2_early"}, 64'(bus.rd_valid), 64'd0);
    tick();
`endif
    check({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
    check({tag, "_data"}, 64'(bus.rd_data), 64'(exp));
  endtask

  task automatic release_bank();
    bus.rd_release = 1'b1;
    tick();
    bus.rd_release = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    bus.flush      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.wr_last    = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.rd_release = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // 1: complete frame in bank0, partial frame in bank1, then async reset
    wr(0, pat(0, 0), 1'b0);
    wr(1, pat(0, 1), 1'b1);
    check("pre_reset_avail", 64'(bus.frame_avail), 64'd1);
    wr(0, pat(0, 2), 1'b0);
    wr(1, pat(0, 3), 1'b0);
    #2 reset = 1'b0;
    #1;
    check("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    check("rst_frame_avail", 64'(bus.frame_avail), 64'd0);
    check("rst_frame_len", 64'(bus.frame_len), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_rd_data", 64'(bus.rd_data), 64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    tick();
    reset = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("rst_read_invalid1", 64'(bus.rd_valid), 64'd0);
    tick();
    check("rst_read_invalid2", 64'(bus.rd_valid), 64'd0);

    // 2: 12-sample frame, in-range read and zero-padded read
    for (int i = 0; i < 12; i++) wr(i, pat(1, i), i == 11);
    check("s2_frame_avail", 64'(bus.frame_avail), 64'd1);
    check("s2_frame_len", 64'(bus.frame_len), 64'd12);
    check("s2_wr_ready", 64'(bus.wr_ready), 64'd1);
    rd(5, pat(1, 5), "s2_rd5");
    rd(11, pat(1, 11), "s2_rd11");
    rd(20, 36'd0, "s2_rd20_pad");
    tick();
    check("s2_valid_drops", 64'(bus.rd_valid), 64'd0);
    release_bank();
    check("s2_rel_avail", 64'(bus.frame_avail), 64'd0);
    check("s2_rel_len", 64'(bus.frame_len), 64'd0);

    // 3: flush back to bank0, fill both banks, dropped write, release
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("s3_flush_ready", 64'(bus.wr_ready), 64'd1);
    for (int i = 0; i < 8; i++) wr(i, pat(2, i), i == 7);
    check("s3_b0_len", 64'(bus.frame_len), 64'd8);
    check("s3_b0_ready", 64'(bus.wr_ready), 64'd1);
    for (int i = 0; i < 4; i++) wr(i, pat(3, i), i == 3);
    check("s3_both_full_ready", 64'(bus.wr_ready), 64'd0);
    check("s3_both_full_len", 64'(bus.frame_len), 64'd8);
    wr(0, pat(9, 0), 1'b0);
    check("s3_overrun", 64'(bus.overrun), 64'd1);
    tick();
    check("s3_overrun_pulse", 64'(bus.overrun), 64'd0);
    rd(0, pat(2, 0), "s3_rd0_intact");
    release_bank();
    check("s3_rel_len", 64'(bus.frame_len), 64'd4);
    check("s3_rel_avail", 64'(bus.frame_avail), 64'd1);
    check("s3_rel_ready", 64'(bus.wr_ready), 64'd1);
    rd(2, pat(3, 2), "s3_rd_b1");
    rd(4, 36'd0, "s3_rd_b1_pad");

    // 4: commit of the write bank and release of the read bank in the same cycle
    for (int i = 0; i < 5; i++) wr(i, pat(4, i), 1'b0);
    bus.rd_release = 1'b1;
    wr(5, pat(4, 5), 1'b1);
    bus.rd_release = 1'b0;
    check("s4_avail", 64'(bus.frame_avail), 64'd1);
    check("s4_len", 64'(bus.frame_len), 64'd6);
    check("s4_ready", 64'(bus.wr_ready), 64'd1);
    check("s4_no_overrun", 64'(bus.overrun), 64'd0);
    rd(5, pat(4, 5), "s4_rd5");
    rd(6, 36'd0, "s4_rd6_pad");

    // 5: out-of-range write, write dropped during release, flush with both banks full
    wr(DEPTH, pat(9, 1), 1'b1);
    check("s5_oor_overrun", 64'(bus.overrun), 64'd1);
    check("s5_oor_ready", 64'(bus.wr_ready), 64'd1);
    check("s5_oor_len", 64'(bus.frame_len), 64'd6);
    wr(0, pat(5, 0), 1'b0);
    wr(1, pat(5, 1), 1'b1);
    check("s5_full_ready", 64'(bus.wr_ready), 64'd0);
    bus.rd_release = 1'b1;
    wr(0, pat(9, 2), 1'b1);
    bus.rd_release = 1'b0;
    check("s5_rel_wr_overrun", 64'(bus.overrun), 64'd1);
    check("s5_rel_wr_len", 64'(bus.frame_len), 64'd2);
    check("s5_rel_wr_ready", 64'(bus.wr_ready), 64'd1);
    rd(1, pat(5, 1), "s5_rd_b1");
    wr(0, pat(6, 0), 1'b1);
    check("s5_refull_ready", 64'(bus.wr_ready), 64'd0);
    bus.flush   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.rd_addr = '0;
    tick();
    bus.flush = 1'b0;
    bus.rd_en = 1'b0;
    check("s5_flush_avail", 64'(bus.frame_avail), 64'd0);
    check("s5_flush_ready", 64'(bus.wr_ready), 64'd1);
    check("s5_flush_len", 64'(bus.frame_len), 64'd0);
    check("s5_flush_valid1", 64'(bus.rd_valid), 64'd0);
    tick();
    check("s5_flush_valid2", 64'(bus.rd_valid), 64'd0);
    for (int i = 0; i < 3; i++) wr(i, pat(7, i), i == 2);
    check("s5_post_flush_len", 64'(bus.frame_len), 64'd3);
    rd(1, pat(7, 1), "s5_post_flush_rd1");
    rd(3, 36'd0, "s5_post_flush_pad");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
